// File: rtl/frame_reducer_if.sv
// Stream bundle between the input buffer, the frame reducer and the packing stage.
// slave = reducer side, master = the upstream/downstream environment driving it.
interface frame_reducer_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                             valid_in;
  logic                             eof_in;
  logic                             op_sel;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_in;
  logic                             out_ready;
  logic                             valid_out;
  logic [N-1:0][DATA_WIDTH-1:0]     vector_out;
  logic [CNT_WIDTH-1:0]             count_out;
  logic                             overflow;

  modport slave (
    input  valid_in, eof_in, op_sel, vector_in, out_ready,
    output valid_out, vector_out, count_out, overflow
  );

  modport master (
    output valid_in, eof_in, op_sel, vector_in, out_ready,
    input  valid_out, vector_out, count_out, overflow
  );
endinterface

// File: rtl/frame_reducer.sv
// Per-lane SUM/MAX reduction of every vector in a frame, result parked in a one-entry output register.
// Optional FRAME_REDUCER_SAT_EN: clamp lanes to the signed DATA_WIDTH range instead of truncating.
module frame_reducer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_reducer_if.slave    bus
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  state_t                           state_q, state_d;
  logic [N-1:0][ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_WIDTH-1:0]             count_q, count_d, count_inc;
  logic                             op_q, op_d;
  logic                             finish;

  logic [N-1:0][ACC_WIDTH-1:0]      lane_ext, lane_sum, lane_max;
  logic [N-1:0][DATA_WIDTH-1:0]     lane_narrow;

  logic                             valid_q, valid_d;
  logic [N-1:0][DATA_WIDTH-1:0]     vec_q, vec_d;
  logic [CNT_WIDTH-1:0]             cnt_out_q, cnt_out_d;
  logic                             ovf_q, ovf_d;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane_ext[gi] = ACC_WIDTH'($signed(bus.vector_in[gi]));
      assign lane_sum[gi] = acc_q[gi] + lane_ext[gi];
      assign lane_max[gi] = ($signed(lane_ext[gi]) > $signed(acc_q[gi])) ? lane_ext[gi] : acc_q[gi];
`ifdef FRAME_REDUCER_SAT_EN
      assign lane_narrow[gi] = ($signed(acc_d[gi]) > $signed(SAT_MAX)) ? SAT_MAX[DATA_WIDTH-1:0] :
                               ($signed(acc_d[gi]) < $signed(SAT_MIN)) ? SAT_MIN[DATA_WIDTH-1:0] :
                               acc_d[gi][DATA_WIDTH-1:0];
`else
      assign lane_narrow[gi] = acc_d[gi][DATA_WIDTH-1:0];
`endif
    end
  endgenerate

  assign count_inc = (&count_q) ? count_q : count_q + CNT_WIDTH'(1);

  // The finishing beat is folded in combinationally so the result lands one cycle after EOF.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    op_d    = op_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          acc_d   = lane_ext;
          count_d = CNT_WIDTH'(1);
          op_d    = bus.op_sel;
          if (bus.eof_in) finish  = 1'b1;
          else            state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.valid_in) begin
          acc_d   = op_q ? lane_max : lane_sum;
          count_d = count_inc;
          if (bus.eof_in) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    vec_d     = vec_q;
    cnt_out_d = cnt_out_q;
    ovf_d     = ovf_q;
    if (finish) begin
      if (!valid_q || bus.out_ready) begin
        valid_d   = 1'b1;
        vec_d     = lane_narrow;
        cnt_out_d = count_d;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      op_q      <= 1'b0;
      valid_q   <= 1'b0;
      vec_q     <= '0;
      cnt_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      vec_q     <= vec_d;
      cnt_out_q <= cnt_out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.vector_out = vec_q;
  assign bus.count_out  = cnt_out_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_frame_reducer.sv
// Randomized bench for frame_reducer against a frame-level reference model (beat queue + arithmetic).
module tb_frame_reducer;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 40;
  localparam int CW = 16;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_reducer_if #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  frame_reducer #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_frames = 0;

  bit   m_valid, m_ovf, m_in_frame, m_op;
  vec_t m_vec;
  int   m_cnt;
  vec_t beats[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t splat(input int x);
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = x;
    return v;
  endfunction

  function automatic vec_t reduce_frame(input bit op);
    vec_t r;
    for (int l = 0; l < N; l++) begin
      longint acc;
      if (op) begin
        acc = longint'($signed(beats[0][l]));
        foreach (beats[b])
          if (longint'($signed(beats[b][l])) > acc) acc = longint'($signed(beats[b][l]));
      end else begin
        acc = 0;
        foreach (beats[b]) acc += longint'($signed(beats[b][l]));
        acc = (acc <<< (64 - AW)) >>> (64 - AW);
`ifdef FRAME_REDUCER_SAT_EN
        if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
      end
      r[l] = acc[DW-1:0];
    end
    return r;
  endfunction

  task automatic model_clock(input bit v, input bit e, input bit op, input vec_t vec, input bit rdy);
    bit   fin = 1'b0;
    vec_t res;
    int   cnt = 0;
    if (v) begin
      if (!m_in_frame) begin
        beats.delete();
        m_op = op;
        m_in_frame = 1'b1;
      end
      beats.push_back(vec);
      if (e) begin
        fin = 1'b1;
        res = reduce_frame(m_op);
        cnt = (beats.size() > 65535) ? 65535 : beats.size();
        m_in_frame = 1'b0;
        n_frames++;
        $display("[TB] frame %0d op=%0d beats=%0d lane0=%0d out_busy=%0d", n_frames, m_op, cnt,
                 $signed(res[0]), m_valid && !rdy);
      end
    end
    if (fin) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_vec   = res;
        m_cnt   = cnt;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid_out"},  256'(bus.valid_out),  256'(m_valid));
    check({tag, ".overflow"},   256'(bus.overflow),   256'(m_ovf));
    check({tag, ".count_out"},  256'(bus.count_out),  256'(m_cnt));
    check({tag, ".vector_out"}, bus.vector_out,       m_vec);
  endtask

  task automatic step(input bit v, input bit e, input bit op, input vec_t vec, input bit rdy);
    bus.valid_in  = v;
    bus.eof_in    = e;
    bus.op_sel    = op;
    bus.vector_in = vec;
    bus.out_ready = rdy;
    @(posedge clk);
    if (rst_n) model_clock(v, e, op, vec, rdy);
    #1;
    compare_all("step");
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    bus.eof_in   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_ovf = 1'b0; m_in_frame = 1'b0; m_vec = '0; m_cnt = 0;
    beats.delete();
    compare_all("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all("in_reset");
    rst_n = 1'b1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < N; l++) begin
      case ($urandom_range(0, 3))
        0: v[l] = DW'($urandom_range(0, 200)) - 32'd100;
        1: v[l] = $urandom;
        2: v[l] = 32'h7FFF_FFFF;
        default: v[l] = 32'h8000_0000;
      endcase
    end
    return v;
  endfunction

  initial begin
    vec_t exp_v;
    bus.valid_in = 1'b0; bus.eof_in = 1'b0; bus.op_sel = 1'b0;
    bus.vector_in = '0;  bus.out_ready = 1'b0;
    #3;
    do_reset();

    // SUM of three beats of 5
    step(1, 0, 0, splat(5), 1);
    step(1, 0, 0, splat(5), 1);
    step(1, 1, 0, splat(5), 1);
    check("t1_sum", bus.vector_out, splat(15));
    check("t1_cnt", 256'(bus.count_out), 256'(3));
    check("t1_valid", 256'(bus.valid_out), 256'(1));

    // MAX with a mid-frame op_sel change that must be ignored
    step(1, 0, 1, splat(-3), 1);
    step(1, 0, 0, splat(7), 1);
    step(1, 1, 0, splat(2), 1);
    check("t2_max", bus.vector_out, splat(7));
    check("t2_cnt", 256'(bus.count_out), 256'(3));
    step(1, 1, 1, splat(-1), 1);
    check("t2_single", bus.vector_out, splat(-1));
    check("t2_single_cnt", 256'(bus.count_out), 256'(1));

    // back-to-back frames
    step(1, 0, 0, splat(1), 1);
    step(1, 1, 0, splat(2), 1);
    check("t4_first", bus.vector_out, splat(3));
    step(1, 0, 0, splat(3), 1);
    step(1, 1, 0, splat(4), 1);
    check("t4_second", bus.vector_out, splat(7));
    check("t4_ovf", 256'(bus.overflow), 256'(0));

    // narrowing boundaries
    step(1, 0, 0, splat(32'h7FFF_FFFF), 1);
    step(1, 1, 0, splat(32'h7FFF_FFFF), 1);
`ifdef FRAME_REDUCER_SAT_EN
    exp_v = splat(32'h7FFF_FFFF);
`else
    exp_v = splat(32'hFFFF_FFFE);
`endif
    check("t5_pos", bus.vector_out, exp_v);
    step(1, 0, 0, splat(32'h8000_0000), 1);
    step(1, 1, 0, splat(32'h8000_0000), 1);
`ifdef FRAME_REDUCER_SAT_EN
    exp_v = splat(32'h8000_0000);
`else
    exp_v = splat(0);
`endif
    check("t5_neg", bus.vector_out, exp_v);

    // drop on busy output register
    step(0, 0, 0, splat(0), 1);
    step(1, 0, 0, splat(4), 0);
    step(1, 1, 0, splat(6), 0);
    step(1, 1, 0, splat(1), 0);
    check("t3_held", bus.vector_out, splat(10));
    check("t3_ovf", 256'(bus.overflow), 256'(1));
    step(0, 0, 0, splat(0), 1);
    check("t3_accept", 256'(bus.valid_out), 256'(0));

    // reset mid-frame
    step(1, 0, 0, splat(2), 1);
    step(1, 0, 0, splat(2), 1);
    do_reset();
    step(1, 1, 0, splat(9), 1);
    check("t6_res", bus.vector_out, splat(9));
    check("t6_cnt", 256'(bus.count_out), 256'(1));
    check("t6_ovf", 256'(bus.overflow), 256'(0));

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)),
           rand_vec(), $urandom_range(0, 9) < 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
